redun_pipe_chk: RTL and testbench
=================================

// Module: redun_pipe_chk
// PURPOSE
//  Pipelined, handshaked redundancy stage on the message path. Each message {src,dst,dat}
//  entering from an upstream node either has its redun field regenerated (GEN mode) or checked
//  against a recomputed value (CHK mode). Mismatches are flagged, optionally dropped, and counted.
//  Sits between node output ports and inter-node links; replaces ad-hoc combinational redun calc.
// PARAMETERS
//  ASZ      `NS_ADDRESS_SIZE  address field width (src and dst)
//  DSZ      `NS_DATA_SIZE     data field width
//  RSZ      `NS_REDUN_SIZE    redundancy width, 1..MSZ
//  RED_FN   1                 0 = per-partition tree_nand reduction, 1 = per-partition XOR parity
//  DROP_BAD 0                 1 = CHK-mode messages that fail are consumed, not forwarded
//  CSZ      8                 error counter width
// PORTS
//  i_clk      in   1    clock
//  reset      in   1    synchronous reset, active high
//  i_chk_en   in   1    0 = GEN, 1 = CHK; sampled with each accepted message
//  src_req    in   1    upstream message valid
//  src_ack    out  1    stage can accept (transfer when src_req && src_ack)
//  src_src    in   ASZ  message source address
//  src_dst    in   ASZ  message destination address
//  src_dat    in   DSZ  message data
//  src_red    in   RSZ  incoming redundancy (ignored in GEN)
//  snk_req    out  1    downstream message valid
//  snk_ack    in   1    downstream accepts (transfer when snk_req && snk_ack)
//  snk_src/snk_dst/snk_dat  out  ASZ/ASZ/DSZ  forwarded fields, unchanged
//  snk_red    out  RSZ  GEN: computed redun; CHK: src_red passed through
//  snk_err    out  1    CHK mismatch on this message; always 0 in GEN
//  i_err_clr  in   1    clear error counter
//  o_err_cnt  out  CSZ  saturating count of CHK mismatches
// BEHAVIOUR
//  - Synchronous reset: s1/s2 valid=0, snk_req=0, snk_err=0, snk_* data=0, o_err_cnt=0;
//    src_ack=1 in the first cycle after reset. Reset mid-transfer discards both stages silently.
//  - Fields: MSZ=2*ASZ+DSZ; full={src,dst,dat}; PART_SZ=MSZ/RSZ; bit i<RSZ-1 covers
//    full[(i+1)*PART_SZ-1 : i*PART_SZ]; bit RSZ-1 covers full[MSZ-1:(RSZ-1)*PART_SZ]
//    (width MSZ%RSZ+PART_SZ). RED_FN=1: bit = ^part; RED_FN=0: bit = tree_nand(part).
//  - Pipeline: S1 registers accepted message + chk_en + src_red; S2 registers computed redun,
//    err = chk_en && (calc != src_red), and drives snk_*. Latency: accept at edge N ->
//    snk_req high after edge N+1. Throughput 1 msg/cycle when snk_ack held high.
//  - Flow: s2_rdy = !s2_v || snk_ack; s1_rdy = !s1_v || s2_rdy; src_ack = s1_rdy.
//    No combinational path snk_ack -> snk_req; snk_* stable while snk_req && !snk_ack.
//  - DROP_BAD=1: an erroring message moving S1->S2 is counted but S2 valid not set; it never
//    appears on snk_req. DROP_BAD=0: forwarded with snk_err=1.
//  - Counter: +1 on each erroring message moving S1->S2; saturates at all-ones (no wrap).
//    i_err_clr same cycle as an increment: clear wins, result 0.
//  - i_chk_en changes mid-stream affect only messages accepted afterwards.
// STRUCTURE
//  - Shared package/hglobal.v: NS_* sizes, RED_FN_NAND/RED_FN_XOR, MODE_GEN/MODE_CHK constants.
//  - Sub-module redun_calc (combinational, generate over RSZ partitions, selects tree_nand or
//    XOR per RED_FN); redun_pipe_chk holds the two stages, flow control and counter.
// TESTING  (ASZ=4, DSZ=8, RSZ=4, RED_FN=1, CSZ=4)
//  - GEN: src=1,dst=2,dat=8'h37, snk_ack=1 -> snk_req 2 cycles later, snk_red=4'hD, snk_err=0.
//  - CHK good: src=A,dst=5,dat=F0,red=0 -> snk_err=0, o_err_cnt stays 0; red=4'h1 -> snk_err=1,
//    cnt=1.
//  - Backpressure: 4 back-to-back msgs, snk_ack=0 for 5 cycles -> src_ack low after 2 accepted,
//    no loss/reorder, snk_* stable; release -> all 4 delivered in order.
//  - DROP_BAD=1: 3 msgs, middle bad -> only 1st and 3rd on snk, cnt=1.
//  - Saturation/clear: 17 bad msgs -> cnt=4'hF; err_clr with a bad msg same cycle -> cnt=0.
//  - Reset with both stages full -> next cycle snk_req=0, src_ack=1, cnt=0.

Source files
------------

// File: rtl/redun_pipe_chk_pkg.sv
// Shared sizes, redundancy function selectors and mode encoding
// for the message-path redundancy stage.
package redun_pipe_chk_pkg;

   localparam int NS_ADDRESS_SIZE = 4;
   localparam int NS_DATA_SIZE    = 8;
   localparam int NS_REDUN_SIZE   = 4;
   localparam int NS_TREE_MAX     = 64;

   localparam int RED_FN_NAND = 0;
   localparam int RED_FN_XOR  = 1;

   typedef enum logic {
      MODE_GEN = 1'b0,
      MODE_CHK = 1'b1
   } mode_e;

   // Balanced NAND tree over the low w bits of v; an odd
   // leftover operand is carried up unchanged to the next level.
   function automatic logic tree_nand(
      input logic [NS_TREE_MAX-1:0] v,
      input int                     w
   );
      logic [NS_TREE_MAX-1:0] t;
      int n;
      t = v;
      n = w;
      for (int l = 0; l < 7; l++) begin
         if (n > 1) begin
            for (int k = 0; k < NS_TREE_MAX / 2; k++) begin
               if (k < n / 2) begin
                  t[k] = ~(t[2*k] & t[2*k+1]);
               end
            end
            if (n % 2 == 1) begin
               t[n/2] = t[n-1];
            end
            n = (n + 1) / 2;
         end
      end
      return t[0];
   endfunction

endpackage

// File: rtl/redun_pipe_chk_calc.sv
// Combinational redundancy calculation: one bit per partition
// of {src,dst,dat}; the top partition absorbs the remainder.
module redun_pipe_chk_calc
   import redun_pipe_chk_pkg::*;
#(
   parameter int MSZ    = 16,
   parameter int RSZ    = 4,
   parameter int RED_FN = RED_FN_XOR
) (
   input  logic [MSZ-1:0] full,
   output logic [RSZ-1:0] red
);

   localparam int PART_SZ = MSZ / RSZ;

   for (genvar i = 0; i < RSZ; i++) begin : g_part
      localparam int LO = i * PART_SZ;
      localparam int W  = (i == RSZ - 1) ? MSZ - LO : PART_SZ;

      logic [W-1:0] part;

      assign part = full[LO+W-1:LO];

      if (RED_FN == RED_FN_XOR) begin : g_xor
         assign red[i] = ^part;
      end else begin : g_nand
         assign red[i] = tree_nand(NS_TREE_MAX'(part), W);
      end
   end

endmodule

// File: rtl/redun_pipe_chk.sv
// Two-stage handshaked redundancy generate/check stage with
// optional drop of failing messages and a saturating error count.
module redun_pipe_chk
   import redun_pipe_chk_pkg::*;
#(
   parameter int ASZ      = NS_ADDRESS_SIZE,
   parameter int DSZ      = NS_DATA_SIZE,
   parameter int RSZ      = NS_REDUN_SIZE,
   parameter int RED_FN   = RED_FN_XOR,
   parameter int DROP_BAD = 0,
   parameter int CSZ      = 8
) (
   input  logic           i_clk,
   input  logic           reset,
   input  logic           i_chk_en,
   input  logic           src_req,
   output logic           src_ack,
   input  logic [ASZ-1:0] src_src,
   input  logic [ASZ-1:0] src_dst,
   input  logic [DSZ-1:0] src_dat,
   input  logic [RSZ-1:0] src_red,
   output logic           snk_req,
   input  logic           snk_ack,
   output logic [ASZ-1:0] snk_src,
   output logic [ASZ-1:0] snk_dst,
   output logic [DSZ-1:0] snk_dat,
   output logic [RSZ-1:0] snk_red,
   output logic           snk_err,
   input  logic           i_err_clr,
   output logic [CSZ-1:0] o_err_cnt
);

   localparam int MSZ = 2 * ASZ + DSZ;

   logic           s1_v_q, s1_v_d;
   logic [ASZ-1:0] s1_src_q, s1_src_d;
   logic [ASZ-1:0] s1_dst_q, s1_dst_d;
   logic [DSZ-1:0] s1_dat_q, s1_dat_d;
   logic [RSZ-1:0] s1_red_q, s1_red_d;
   mode_e          s1_mode_q, s1_mode_d;

   logic           s2_v_q, s2_v_d;
   logic [ASZ-1:0] s2_src_q, s2_src_d;
   logic [ASZ-1:0] s2_dst_q, s2_dst_d;
   logic [DSZ-1:0] s2_dat_q, s2_dat_d;
   logic [RSZ-1:0] s2_red_q, s2_red_d;
   logic           s2_err_q, s2_err_d;

   logic [CSZ-1:0] cnt_q, cnt_d;

   logic [RSZ-1:0] calc;
   logic           s1_rdy, s2_rdy;
   logic           acc, mv, bad, keep;

   redun_pipe_chk_calc #(
      .MSZ    (MSZ),
      .RSZ    (RSZ),
      .RED_FN (RED_FN)
   ) u_calc (
      .full ({s1_src_q, s1_dst_q, s1_dat_q}),
      .red  (calc)
   );

   assign s2_rdy  = !s2_v_q || snk_ack;
   assign s1_rdy  = !s1_v_q || s2_rdy;
   assign src_ack = s1_rdy;
   assign acc     = src_req && s1_rdy;
   assign mv      = s1_v_q && s2_rdy;
   assign bad     = (s1_mode_q == MODE_CHK) && (calc != s1_red_q);
   assign keep    = !((DROP_BAD != 0) && bad);

   // Stage 1: capture accepted message and its mode
   always_comb begin
      s1_v_d    = s1_v_q;
      s1_src_d  = s1_src_q;
      s1_dst_d  = s1_dst_q;
      s1_dat_d  = s1_dat_q;
      s1_red_d  = s1_red_q;
      s1_mode_d = s1_mode_q;
      if (acc) begin
         s1_v_d    = 1'b1;
         s1_src_d  = src_src;
         s1_dst_d  = src_dst;
         s1_dat_d  = src_dat;
         s1_red_d  = src_red;
         s1_mode_d = mode_e'(i_chk_en);
      end else if (mv) begin
         s1_v_d = 1'b0;
      end
   end

   // Stage 2: register result, drop failing messages if enabled
   always_comb begin
      s2_v_d   = s2_v_q;
      s2_src_d = s2_src_q;
      s2_dst_d = s2_dst_q;
      s2_dat_d = s2_dat_q;
      s2_red_d = s2_red_q;
      s2_err_d = s2_err_q;
      if (mv) begin
         s2_v_d = keep;
         if (keep) begin
            s2_src_d = s1_src_q;
            s2_dst_d = s1_dst_q;
            s2_dat_d = s1_dat_q;
            s2_red_d = (s1_mode_q == MODE_CHK) ? s1_red_q : calc;
            s2_err_d = bad;
         end
      end else if (snk_ack) begin
         s2_v_d = 1'b0;
      end
   end

   // Error counter: clear has priority, increment saturates
   always_comb begin
      cnt_d = cnt_q;
      if (i_err_clr) begin
         cnt_d = '0;
      end else if (mv && bad && (cnt_q != {CSZ{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge i_clk) begin
      if (reset) begin
         s1_v_q    <= 1'b0;
         s1_src_q  <= '0;
         s1_dst_q  <= '0;
         s1_dat_q  <= '0;
         s1_red_q  <= '0;
         s1_mode_q <= MODE_GEN;
         s2_v_q    <= 1'b0;
         s2_src_q  <= '0;
         s2_dst_q  <= '0;
         s2_dat_q  <= '0;
         s2_red_q  <= '0;
         s2_err_q  <= 1'b0;
         cnt_q     <= '0;
      end else begin
         s1_v_q    <= s1_v_d;
         s1_src_q  <= s1_src_d;
         s1_dst_q  <= s1_dst_d;
         s1_dat_q  <= s1_dat_d;
         s1_red_q  <= s1_red_d;
         s1_mode_q <= s1_mode_d;
         s2_v_q    <= s2_v_d;
         s2_src_q  <= s2_src_d;
         s2_dst_q  <= s2_dst_d;
         s2_dat_q  <= s2_dat_d;
         s2_red_q  <= s2_red_d;
         s2_err_q  <= s2_err_d;
         cnt_q     <= cnt_d;
      end
   end

   assign snk_req   = s2_v_q;
   assign snk_src   = s2_src_q;
   assign snk_dst   = s2_dst_q;
   assign snk_dat   = s2_dat_q;
   assign snk_red   = s2_red_q;
   assign snk_err   = s2_err_q;
   assign o_err_cnt = cnt_q;

endmodule

// File: tb/tb_redun_pipe_chk.sv
// Bench for redun_pipe_chk: random and directed messages
// against a parity reference model and scoreboard queues.
module tb_redun_pipe_chk;

   localparam int ASZ = 4;
   localparam int DSZ = 8;
   localparam int RSZ = 4;
   localparam int CSZ = 4;

   logic clk = 1'b0;
   logic reset;
   logic chk_en, err_clr, d_clr;
   logic src_req, d_req, snk_ack, d_ack;
   logic [ASZ-1:0] src_src, src_dst;
   logic [DSZ-1:0] src_dat;
   logic [RSZ-1:0] src_red;

   logic src_ack, snk_req, snk_err;
   logic [ASZ-1:0] snk_src, snk_dst;
   logic [DSZ-1:0] snk_dat;
   logic [RSZ-1:0] snk_red;
   logic [CSZ-1:0] err_cnt;

   logic d_src_ack, d_snk_req, d_snk_err;
   logic [ASZ-1:0] d_snk_src, d_snk_dst;
   logic [DSZ-1:0] d_snk_dat;
   logic [RSZ-1:0] d_snk_red;
   logic [CSZ-1:0] d_err_cnt;

   int checks = 0;
   int errors = 0;
   int ack_mode = 1;
   int exp_cnt = 0;
   int d_exp_cnt = 0;
   int n_main = 0;
   int n_drp = 0;

   typedef struct {
      logic [ASZ-1:0] s;
      logic [ASZ-1:0] d;
      logic [DSZ-1:0] dat;
      logic [RSZ-1:0] red;
      logic           err;
   } exp_t;

   exp_t q[$];
   exp_t dq[$];

   logic        h_v;
   logic [31:0] h_val;

   always #5 clk = ~clk;

   redun_pipe_chk #(
      .ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ),
      .RED_FN(1), .DROP_BAD(0), .CSZ(CSZ)
   ) u_dut (
      .i_clk(clk), .reset(reset), .i_chk_en(chk_en),
      .src_req(src_req), .src_ack(src_ack),
      .src_src(src_src), .src_dst(src_dst),
      .src_dat(src_dat), .src_red(src_red),
      .snk_req(snk_req), .snk_ack(snk_ack),
      .snk_src(snk_src), .snk_dst(snk_dst),
      .snk_dat(snk_dat), .snk_red(snk_red),
      .snk_err(snk_err), .i_err_clr(err_clr),
      .o_err_cnt(err_cnt)
   );

   redun_pipe_chk #(
      .ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ),
      .RED_FN(1), .DROP_BAD(1), .CSZ(CSZ)
   ) u_drp (
      .i_clk(clk), .reset(reset), .i_chk_en(chk_en),
      .src_req(d_req), .src_ack(d_src_ack),
      .src_src(src_src), .src_dst(src_dst),
      .src_dat(src_dat), .src_red(src_red),
      .snk_req(d_snk_req), .snk_ack(d_ack),
      .snk_src(d_snk_src), .snk_dst(d_snk_dst),
      .snk_dat(d_snk_dat), .snk_red(d_snk_red),
      .snk_err(d_snk_err), .i_err_clr(d_clr),
      .o_err_cnt(d_err_cnt)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // Reference: parity of each partition, counted bit by bit
   function automatic logic [RSZ-1:0] model_red(
      input logic [ASZ-1:0] s, input logic [ASZ-1:0] d,
      input logic [DSZ-1:0] dt);
      logic [2*ASZ+DSZ-1:0] full;
      logic [RSZ-1:0] r;
      int msz, psz, lo, w, ones;
      full = {s, d, dt};
      msz = 2 * ASZ + DSZ;
      psz = msz / RSZ;
      r = '0;
      for (int i = 0; i < RSZ; i++) begin
         lo = i * psz;
         w = (i == RSZ - 1) ? msz - lo : psz;
         ones = 0;
         for (int b = 0; b < w; b++) ones += int'(full[lo+b]);
         r[i] = (ones % 2) == 1;
      end
      return r;
   endfunction

   function automatic exp_t mk(
      input logic [ASZ-1:0] s, input logic [ASZ-1:0] d,
      input logic [DSZ-1:0] dt, input logic [RSZ-1:0] r,
      input logic c);
      exp_t e;
      logic [RSZ-1:0] cr;
      cr = model_red(s, d, dt);
      e.s = s;
      e.d = d;
      e.dat = dt;
      e.red = c ? r : cr;
      e.err = c && (r != cr);
      return e;
   endfunction

   // Downstream ready pattern
   initial begin
      snk_ack = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         case (ack_mode)
            0: snk_ack = 1'b0;
            1: snk_ack = 1'b1;
            default: snk_ack = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   // Scoreboards and output-hold monitor
   always @(negedge clk) begin
      if (reset) begin
         h_v = 1'b0;
      end else begin
         if (src_req && src_ack)
            q.push_back(mk(src_src, src_dst, src_dat, src_red, chk_en));
         if (d_req && d_src_ack) begin
            exp_t e;
            e = mk(src_src, src_dst, src_dat, src_red, chk_en);
            if (!e.err) dq.push_back(e);
         end
         if (h_v && snk_req)
            check("hold", {snk_src, snk_dst, snk_dat, snk_red, snk_err}, h_val);
         if (snk_req && snk_ack) begin
            if (q.size() == 0) begin
               check("sb_extra", 1, 0);
            end else begin
               exp_t e;
               e = q.pop_front();
               check("snk_msg", {snk_src, snk_dst, snk_dat},
                     {e.s, e.d, e.dat});
               check("snk_red", snk_red, e.red);
               check("snk_err", snk_err, e.err);
               n_main++;
            end
         end
         if (d_snk_req && d_ack) begin
            if (dq.size() == 0) begin
               check("drp_extra", 1, 0);
            end else begin
               exp_t e;
               e = dq.pop_front();
               check("drp_msg", {d_snk_src, d_snk_dst, d_snk_dat},
                     {e.s, e.d, e.dat});
               check("drp_red", d_snk_red, e.red);
               check("drp_err", d_snk_err, e.err);
               n_drp++;
            end
         end
         h_v = snk_req && !snk_ack;
         h_val = {11'd0, snk_src, snk_dst, snk_dat, snk_red, snk_err};
      end
   end

   task automatic send(input bit drp, input logic [ASZ-1:0] s,
                       input logic [ASZ-1:0] d, input logic [DSZ-1:0] dt,
                       input logic [RSZ-1:0] r, input logic c);
      int g;
      bit ok;
      bit bad;
      g = 0;
      ok = 1'b0;
      src_src = s;
      src_dst = d;
      src_dat = dt;
      src_red = r;
      chk_en = c;
      if (drp) d_req = 1'b1;
      else src_req = 1'b1;
      while (!ok && g < 200) begin
         @(negedge clk);
         g++;
         ok = drp ? d_src_ack : src_ack;
      end
      if (!ok) check("send_timeout", 0, 1);
      @(posedge clk);
      #1;
      src_req = 1'b0;
      d_req = 1'b0;
      bad = c && (r != model_red(s, d, dt));
      if (bad && !drp && exp_cnt < 15) exp_cnt++;
      if (bad && drp && d_exp_cnt < 15) d_exp_cnt++;
   endtask

   task automatic drain();
      int g;
      g = 0;
      while ((q.size() != 0 || dq.size() != 0) && g < 300) begin
         @(posedge clk);
         g++;
      end
      #1;
      check("drain", q.size() + dq.size(), 0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   function automatic logic [ASZ-1:0] ra();
      return ASZ'($urandom_range(0, 15));
   endfunction

   initial begin
      logic [ASZ-1:0] s, d;
      logic [DSZ-1:0] dt;
      logic [RSZ-1:0] r;
      logic c;
      int n0;
      reset = 1'b1;
      chk_en = 1'b0;
      err_clr = 1'b0;
      d_clr = 1'b0;
      src_req = 1'b0;
      d_req = 1'b0;
      d_ack = 1'b1;
      src_src = '0;
      src_dst = '0;
      src_dat = '0;
      src_red = '0;
      h_v = 1'b0;
      h_val = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      check("rst_req", snk_req, 0);
      check("rst_ack", src_ack, 1);
      check("rst_cnt", err_cnt, 0);
      check("rst_err", snk_err, 0);
      check("rst_dat", {snk_src, snk_dst, snk_dat, snk_red}, 0);

      send(0, 4'h1, 4'h2, 8'h37, 4'h0, 1'b0);
      check("lat_early", snk_req, 0);
      @(posedge clk);
      #1;
      check("lat_req", snk_req, 1);
      check("gen_red", snk_red, 4'hD);
      check("gen_err", snk_err, 0);
      drain();

      send(0, 4'hA, 4'h5, 8'hF0, 4'h0, 1'b1);
      drain();
      check("chk_good_cnt", err_cnt, 0);
      send(0, 4'hA, 4'h5, 8'hF0, 4'h1, 1'b1);
      @(posedge clk);
      #1;
      check("chk_bad_err", snk_err, 1);
      drain();
      check("chk_bad_cnt", err_cnt, 1);

      ack_mode = 0;
      n0 = n_main;
      send(0, 4'h3, 4'h4, 8'h11, 4'h0, 1'b0);
      send(0, 4'h5, 4'h6, 8'h22, 4'h0, 1'b0);
      @(negedge clk);
      check("bp_ack_low", src_ack, 0);
      @(posedge clk);
      #1;
      fork
         begin
            send(0, 4'h7, 4'h8, 8'h33, 4'h0, 1'b0);
            send(0, 4'h9, 4'hA, 8'h44, 4'h0, 1'b0);
         end
         begin
            repeat (5) @(posedge clk);
            ack_mode = 1;
         end
      join
      drain();
      check("bp_count", n_main - n0, 4);

      n0 = n_drp;
      send(1, 4'h1, 4'h1, 8'hA5, model_red(4'h1, 4'h1, 8'hA5), 1'b1);
      send(1, 4'h2, 4'h2, 8'h5A, ~model_red(4'h2, 4'h2, 8'h5A), 1'b1);
      send(1, 4'h3, 4'h3, 8'hC3, model_red(4'h3, 4'h3, 8'hC3), 1'b1);
      drain();
      check("drp_count", n_drp - n0, 2);
      check("drp_cnt", d_err_cnt, d_exp_cnt);

      for (int i = 0; i < 17; i++) begin
         s = ra();
         d = ra();
         dt = DSZ'($urandom);
         send(0, s, d, dt, model_red(s, d, dt) ^ 4'h1, 1'b1);
      end
      drain();
      check("sat_cnt", err_cnt, exp_cnt);
      check("sat_all1", err_cnt, 4'hF);

      send(0, 4'h6, 4'h6, 8'h66, 4'hF, 1'b1);
      err_clr = 1'b1;
      @(posedge clk);
      #1;
      err_clr = 1'b0;
      exp_cnt = 0;
      check("clr_wins", err_cnt, 0);
      drain();

      ack_mode = 2;
      for (int i = 0; i < 150; i++) begin
         s = ra();
         d = ra();
         dt = DSZ'($urandom);
         c = 1'($urandom_range(0, 1));
         r = ($urandom_range(0, 1) == 1) ? model_red(s, d, dt)
                                         : RSZ'($urandom_range(0, 15));
         send(0, s, d, dt, r, c);
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
      end
      ack_mode = 1;
      drain();
      check("rnd_cnt", err_cnt, exp_cnt);

      ack_mode = 0;
      send(0, 4'h1, 4'h2, 8'h03, 4'h0, 1'b1);
      send(0, 4'h4, 4'h5, 8'h06, 4'h0, 1'b1);
      @(negedge clk);
      check("full_ack", src_ack, 0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      q.delete();
      exp_cnt = 0;
      check("rst2_req", snk_req, 0);
      check("rst2_ack", src_ack, 1);
      check("rst2_cnt", err_cnt, 0);
      ack_mode = 1;
      repeat (3) @(posedge clk);
      #1;
      check("rst2_idle", snk_req, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
